// File: rtl/life_scan_ctrl_pkg.sv
// Shared definitions for the life-array scan controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package life_scan_ctrl_pkg;

    localparam int DEF_CHAIN_LEN = 16;
    localparam int DEF_GEN_W     = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DUMP,
        ST_RUN,
        ST_DONE
    } state_e;

    // Width of a counter that must reach n without wrapping.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/life_scan_ctrl_if.sv
// Command and array-scan signal bundle between a host and life_scan_ctrl.
// Latency: n/a (wires only).
// Backpressure: none; busy tells the host when commands are dropped.
// Ports: master = host side (commands, load data, chain read-back),
//        slave  = controller side (scan/run strobes, busy/done, dump data).
interface life_scan_ctrl_if #(
    parameter int CHAIN_LEN = life_scan_ctrl_pkg::DEF_CHAIN_LEN,
    parameter int GEN_W     = life_scan_ctrl_pkg::DEF_GEN_W
);
    logic                 cmd_load;
    logic                 cmd_dump;
    logic                 cmd_run;
    logic [CHAIN_LEN-1:0] load_pattern;
    logic [GEN_W-1:0]     gen_count;
    logic                 scan;
    logic                 scan_write_val;
    logic                 scan_write_enb;
    logic                 scan_read_val;
    logic                 run;
    logic                 busy;
    logic                 done;
    logic [CHAIN_LEN-1:0] dump_pattern;

    modport master (
        output cmd_load, cmd_dump, cmd_run, load_pattern, gen_count, scan_read_val,
        input  scan, scan_write_val, scan_write_enb, run, busy, done, dump_pattern
    );

    modport slave (
        input  cmd_load, cmd_dump, cmd_run, load_pattern, gen_count, scan_read_val,
        output scan, scan_write_val, scan_write_enb, run, busy, done, dump_pattern
    );
endinterface

// File: rtl/life_scan_shifter.sv
// Scan data path: parallel-load/serial-out for LOAD, serial-in/parallel-out for DUMP.
// Latency: ser_o valid the cycle after load_i; cap_o is the post-shift value, combinational.
// Backpressure: none; shifts whenever shift_i is high.
// Ports: clk_i/reset_i, load_i + pattern_i (parallel load, clears bit count),
//        shift_i, ser_i -> shifted in at MSB, ser_o = LSB, last_o = final shift cycle.
module life_scan_shifter
    import life_scan_ctrl_pkg::*;
#(
    parameter int CHAIN_LEN = DEF_CHAIN_LEN
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 load_i,
    input  logic [CHAIN_LEN-1:0] pattern_i,
    input  logic                 shift_i,
    input  logic                 ser_i,
    output logic                 ser_o,
    output logic                 last_o,
    output logic [CHAIN_LEN-1:0] cap_o
);
    localparam int CNT_W = cnt_width(CHAIN_LEN);

    logic [CNT_W-1:0]     cnt_q;
    logic [CHAIN_LEN-1:0] sreg_q;

    // One register serves both directions: bits leave at the LSB and arrive
    // at the MSB, so after CHAIN_LEN shifts the first bit read lands in bit 0.
    assign cap_o  = {ser_i, sreg_q[CHAIN_LEN-1:1]};
    assign ser_o  = sreg_q[0];
    assign last_o = (cnt_q == CNT_W'(CHAIN_LEN - 1));

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q  <= '0;
            sreg_q <= '0;
        end else if (load_i) begin
            cnt_q  <= '0;
            sreg_q <= pattern_i;
        end else if (shift_i) begin
            cnt_q  <= cnt_q + CNT_W'(1);
            sreg_q <= cap_o;
        end
    end
endmodule

// File: rtl/life_scan_ctrl.sv
// Sequences LOAD / DUMP scan passes and RUN generation bursts on a life cell array.
// Latency: LOAD/DUMP done CHAIN_LEN+1 cycles after acceptance, RUN gen_count+1.
// Backpressure: commands only accepted in IDLE; anything seen while busy is dropped.
// Ports: clk, reset (sync, active-high), bus = life_scan_ctrl_if.slave carrying
//        commands/load data in and scan/run strobes, busy/done, dump_pattern out.
module life_scan_ctrl
    import life_scan_ctrl_pkg::*;
#(
    parameter int CHAIN_LEN = DEF_CHAIN_LEN,
    parameter int GEN_W     = DEF_GEN_W
) (
    input  logic             clk,
    input  logic             reset,
    life_scan_ctrl_if.slave  bus
);
    state_e               state_q, state_d;
    logic [GEN_W-1:0]     gen_q, gen_d;
    logic [CHAIN_LEN-1:0] dump_q;
    logic [CHAIN_LEN-1:0] cap;
    logic                 accept;
    logic                 sh_shift, sh_ser_in, sh_ser_out, sh_last;
    logic                 scan_c, wenb_c, wval_c, run_c, busy_c, done_c;

    assign accept    = (state_q == ST_IDLE) && (bus.cmd_load || bus.cmd_dump || bus.cmd_run);
    assign sh_shift  = (state_q == ST_LOAD) || (state_q == ST_DUMP);
    assign sh_ser_in = (state_q == ST_DUMP) && bus.scan_read_val;

    life_scan_shifter #(.CHAIN_LEN(CHAIN_LEN)) u_shifter (
        .clk_i     (clk),
        .reset_i   (reset),
        .load_i    (accept),
        .pattern_i (bus.load_pattern),
        .shift_i   (sh_shift),
        .ser_i     (sh_ser_in),
        .ser_o     (sh_ser_out),
        .last_o    (sh_last),
        .cap_o     (cap)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            gen_q   <= '0;
            dump_q  <= '0;
        end else begin
            state_q <= state_d;
            gen_q   <= gen_d;
            // All captured bits publish together on the edge into DONE.
            if ((state_q == ST_DUMP) && sh_last) begin
                dump_q <= cap;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        gen_d   = gen_q;
        scan_c  = 1'b0;
        wenb_c  = 1'b0;
        wval_c  = 1'b0;
        run_c   = 1'b0;
        busy_c  = 1'b1;
        done_c  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                busy_c = 1'b0;
                if (accept) begin
                    gen_d = bus.gen_count;
                end
                if (bus.cmd_load) begin
                    state_d = ST_LOAD;
                end else if (bus.cmd_dump) begin
                    state_d = ST_DUMP;
                end else if (bus.cmd_run) begin
                    // Zero generations skips RUN so run is never pulsed.
                    state_d = (bus.gen_count == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_LOAD: begin
                scan_c = 1'b1;
                wenb_c = 1'b1;
                wval_c = sh_ser_out;
                if (sh_last) state_d = ST_DONE;
            end
            ST_DUMP: begin
                // Write-enable low: the array recirculates its tail to its head.
                scan_c = 1'b1;
                if (sh_last) state_d = ST_DONE;
            end
            ST_RUN: begin
                run_c = 1'b1;
                gen_d = gen_q - GEN_W'(1);
                if (gen_q == GEN_W'(1)) state_d = ST_DONE;
            end
            ST_DONE: begin
                done_c  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                busy_c  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs are forced low for the whole reset cycle, not just after the edge.
    assign bus.scan           = scan_c & ~reset;
    assign bus.scan_write_enb = wenb_c & ~reset;
    assign bus.scan_write_val = wval_c & ~reset;
    assign bus.run            = run_c  & ~reset;
    assign bus.busy           = busy_c & ~reset;
    assign bus.done           = done_c & ~reset;
    assign bus.dump_pattern   = reset ? '0 : dump_q;
endmodule
